alu_sequencer: RTL and testbench

Sequencer for the 4-bit add/subtract ArithmeticUnit.
- Owns the two operand registers and loads them from a 4-bit data input.
- Drives the unit's A, B, AddSub and EnableAlu pins, and captures the result from the internal bus IB_Alu together with Carry.
- Optionally repeats the operation, feeding the result back as the next B operand (accumulate mode).
- Sits between the control logic that issues requests and the ArithmeticUnit on the internal bus.

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/alu_iter_counter.sv | 36 +++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and its iteration counter.
package alu_seq_pkg;

    localparam int unsigned DW = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StDone
    } state_e;

endpackage

// File: rtl/alu_iter_counter.sv
// Loadable down-counter tracking the remaining EXEC iterations.
module alu_iter_counter
    import alu_seq_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [DW-1:0] cnt_o,
    output logic          zero_o
);

    logic [DW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences operand loads, EXEC iterations and result capture for the 4-bit add/subtract unit.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          sub_i,
    input  logic [DW-1:0] count_i,
    input  logic [DW-1:0] data_in_i,
    input  logic [DW-1:0] ib_alu_i,
    input  logic          carry_i,
    output logic [DW-1:0] op_a_o,
    output logic [DW-1:0] op_b_o,
    output logic          add_sub_o,
    output logic          enable_alu_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] result_o,
    output logic          carry_flag_o,
    output logic          zero_flag_o,
    output logic          carry_sticky_o
);

    state_e        state_d, state_q;
    logic          sub_d, sub_q;
    logic [DW-1:0] op_a_d, op_a_q;
    logic [DW-1:0] op_b_d, op_b_q;
    logic [DW-1:0] result_d, result_q;
    logic          carry_flag_d, carry_flag_q;
    logic          zero_flag_d, zero_flag_q;
    logic          carry_sticky_d, carry_sticky_q;

    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [DW-1:0] cnt_val;

    alu_iter_counter u_iter_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (count_i),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d        = state_q;
        sub_d          = sub_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result_q;
        carry_flag_d   = carry_flag_q;
        zero_flag_d    = zero_flag_q;
        carry_sticky_d = carry_sticky_q;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sub_d          = sub_i;
                    carry_sticky_d = 1'b0;
                    cnt_load       = 1'b1;
                    state_d        = StLoadA;
                end
            end
            StLoadA: begin
                op_a_d  = data_in_i;
                state_d = StLoadB;
            end
            StLoadB: begin
                op_b_d  = data_in_i;
                state_d = StExec;
            end
            StExec: begin
                // Result feeds back as next B operand for accumulate mode.
                result_d       = ib_alu_i;
                op_b_d         = ib_alu_i;
                carry_flag_d   = carry_i;
                carry_sticky_d = carry_sticky_q | carry_i;
                zero_flag_d    = (ib_alu_i == '0);
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            sub_q          <= OP_ADD;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            carry_flag_q   <= 1'b0;
            zero_flag_q    <= 1'b0;
            carry_sticky_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sub_q          <= sub_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            result_q       <= result_d;
            carry_flag_q   <= carry_flag_d;
            zero_flag_q    <= zero_flag_d;
            carry_sticky_q <= carry_sticky_d;
        end
    end

    // Decoded straight from the state register so reset drops the bus enable without a clock.
    assign enable_alu_o   = (state_q == StExec);
    assign add_sub_o      = (state_q == StExec) && (sub_q == OP_SUB);
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign result_o       = result_q;
    assign carry_flag_o   = carry_flag_q;
    assign zero_flag_o    = zero_flag_q;
    assign carry_sticky_o = carry_sticky_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural add/subtract unit.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [3:0] count;
    logic [3:0] data_in;
    logic [3:0] ib_alu;
    logic       carry;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       add_sub;
    logic       enable_alu;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       carry_flag;
    logic       zero_flag;
    logic       carry_sticky;

    int n_total = 0;
    int n_bad   = 0;
    int prev_res;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .sub_i          (sub),
        .count_i        (count),
        .data_in_i      (data_in),
        .ib_alu_i       (ib_alu),
        .carry_i        (carry),
        .op_a_o         (op_a),
        .op_b_o         (op_b),
        .add_sub_o      (add_sub),
        .enable_alu_o   (enable_alu),
        .busy_o         (busy),
        .done_o         (done),
        .result_o       (result),
        .carry_flag_o   (carry_flag),
        .zero_flag_o    (zero_flag),
        .carry_sticky_o (carry_sticky)
    );

    // The arithmetic unit on the bus: B+A or B+~A+1, driving the bus only when enabled.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        if (add_sub) alu_sum = {1'b0, op_b} + {1'b0, ~op_a} + 5'd1;
        else         alu_sum = {1'b0, op_b} + {1'b0, op_a};
        ib_alu = enable_alu ? alu_sum[3:0] : 4'd0;
        carry  = enable_alu & alu_sum[4];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic s, input int cnt, input int a, input int b, input bit spam);
        int  bb;
        int  c;
        int  lastc;
        int  sticky;
        int  opb_exp[$];
        int  done_k;
        int  en_cycles;
        int  i;
        int  late_busy;

        // Reference: Count+1 iterations of B := B op A modulo 16.
        bb = b; sticky = 0; lastc = 0;
        for (int j = 0; j <= cnt; j++) begin
            opb_exp.push_back(bb);
            if (s) begin
                c  = (bb >= a) ? 1 : 0;
                bb = (bb - a + 16) % 16;
            end else begin
                c  = (bb + a > 15) ? 1 : 0;
                bb = (bb + a) % 16;
            end
            sticky = sticky | c;
            lastc  = c;
        end

        start = 1'b1; sub = s; count = cnt[3:0]; data_in = 4'($urandom);
        tick();  // E0
        check_val("busy_after_start", busy, 1);
        check_val("res_hold_on_start", result, prev_res);
        start = 1'b0; sub = 1'($urandom); count = 4'($urandom); data_in = a[3:0];
        tick();  // E1
        check_val("op_a_load", op_a, a);
        data_in = b[3:0];
        if (spam) start = 1'b1;

        done_k = -1; en_cycles = 0; i = 0;
        for (int k = 2; k < cnt + 12 && done_k < 0; k++) begin
            tick();
            data_in = 4'($urandom);
            if (enable_alu) begin
                if (i < opb_exp.size()) check_val("op_b_iter", op_b, opb_exp[i]);
                check_val("op_a_held", op_a, a);
                check_val("add_sub_exec", add_sub, s);
                i++;
                en_cycles++;
            end else begin
                check_val("add_sub_idle", add_sub, 0);
            end
            if (done) done_k = k;
        end
        check_val("done_latency", done_k, cnt + 3);
        check_val("enable_cycles", en_cycles, cnt + 1);
        check_val("result", result, bb);
        check_val("carry_flag", carry_flag, lastc);
        check_val("zero_flag", zero_flag, (bb == 0) ? 1 : 0);
        check_val("carry_sticky", carry_sticky, sticky);
        check_val("op_b_final", op_b, bb);

        tick();  // leaves DONE even if Start is held
        check_val("done_one_cycle", done, 0);
        check_val("idle_after_done", busy, 0);
        start = 1'b0;
        if (spam) begin
            late_busy = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (busy || done) late_busy = 1;
            end
            check_val("no_queued_start", late_busy, 0);
        end
        prev_res = bb;
    endtask

    initial begin
        int saw_done;

        rst = 1'b1; start = 1'b0; sub = 1'b0; count = '0; data_in = '0;
        prev_res = 0;
        #2;
        check_val("rst_enable", enable_alu, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_add_sub", add_sub, 0);
        check_val("rst_result", result, 0);
        check_val("rst_op_b", op_b, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op(1'b0, 0, 3, 5, 1'b0);
        run_op(1'b1, 0, 5, 3, 1'b0);
        run_op(1'b1, 0, 3, 5, 1'b0);
        run_op(1'b1, 0, 8, 8, 1'b0);
        run_op(1'b0, 5, 3, 0, 1'b0);
        run_op(1'b1, 2, 7, 9, 1'b1);

        // Reset in the middle of a long accumulate.
        start = 1'b1; sub = 1'b0; count = 4'd7;
        tick();
        start = 1'b0; data_in = 4'd3;
        tick();
        data_in = 4'd4;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_val("midrst_enable", enable_alu, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_result", result, 0);
        check_val("midrst_flags", {carry_flag, zero_flag, carry_sticky}, 0);
        check_val("midrst_ops", {op_a, op_b}, 0);
        tick();
        rst = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        check_val("midrst_no_done", saw_done, 0);
        prev_res = 0;
        run_op(1'b0, 0, 1, 1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
